// File: rtl/riscboy_ppu_palette_loader.sv
// ----------------------------------------------------------------------------
// riscboy_ppu_palette_loader
//
// Purpose:
//   This block owns the palette RAM write port of the palette mapper. Two
//   requesters share that one port:
//     - CPU register writes. Each one writes a single entry. The CPU path has
//       no backpressure and always wins the port.
//     - A burst loader. It takes a (base, count) command, then streams count
//       entries from a valid/ready source into consecutive palette indices.
//       The index wraps modulo the palette depth.
//   The write port is registered. A request accepted in cycle N appears on
//   pram_* in cycle N+1. A write is never dropped or duplicated.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy         burst command handshake (cmd_rdy = idle)
//   cmd_base, cmd_count     first index, number of entries (0..depth)
//   abort                   cancels a running burst (ignored when idle)
//   src_vld/src_rdy         burst data handshake
//   src_data                burst palette entry
//   cpu_wen/cpu_waddr/      CPU single-entry write
//   cpu_wdata
//   busy                    burst in progress
//   done                    one-cycle pulse when a burst completes normally
//   pram_waddr/pram_wdata/  registered write port toward the palette mapper
//   pram_wen
// ----------------------------------------------------------------------------
module riscboy_ppu_palette_loader #(
  parameter int W_PIXDATA     = 16,
  parameter int W_PALETTE_IDX = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     cmd_vld,
  output logic                     cmd_rdy,
  input  logic [W_PALETTE_IDX-1:0] cmd_base,
  input  logic [W_PALETTE_IDX:0]   cmd_count,
  input  logic                     abort,

  input  logic                     src_vld,
  output logic                     src_rdy,
  input  logic [W_PIXDATA-1:0]     src_data,

  input  logic                     cpu_wen,
  input  logic [W_PALETTE_IDX-1:0] cpu_waddr,
  input  logic [W_PIXDATA-1:0]     cpu_wdata,

  output logic                     busy,
  output logic                     done,

  output logic [W_PALETTE_IDX-1:0] pram_waddr,
  output logic [W_PIXDATA-1:0]     pram_wdata,
  output logic                     pram_wen
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                   r_state;
  logic [W_PALETTE_IDX-1:0] r_ptr;
  logic [W_PALETTE_IDX:0]   r_rem;
  logic                     r_done;
  logic                     r_wen;
  logic [W_PALETTE_IDX-1:0] r_waddr;
  logic [W_PIXDATA-1:0]     r_wdata;

  logic w_idle;
  logic w_run;
  logic w_cmd_acc;
  logic w_cmd_zero;
  logic w_src_rdy;
  logic w_beat;
  logic w_last;

  // --------------------------------------------------------------------------
  // Handshake decode (combinational)
  // --------------------------------------------------------------------------
  assign w_idle     = (r_state == S_IDLE);
  assign w_run      = (r_state == S_RUN);
  assign w_cmd_acc  = cmd_vld && w_idle;
  assign w_cmd_zero = (cmd_count == '0);
  // The CPU owns the port in any cycle where it writes. An abort cycle
  // consumes no beat either, so the source is held off in both cases.
  assign w_src_rdy  = w_run && !cpu_wen && !abort;
  assign w_beat     = src_vld && w_src_rdy;
  assign w_last     = (r_rem == (W_PALETTE_IDX+1)'(1));

  assign cmd_rdy    = w_idle;
  assign busy       = w_run;
  assign src_rdy    = w_src_rdy;
  assign done       = r_done;
  assign pram_wen   = r_wen;
  assign pram_waddr = r_waddr;
  assign pram_wdata = r_wdata;

  // --------------------------------------------------------------------------
  // Registered write port + burst sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      r_wen  <= 1'b0;

      // The CPU write wins the port outright. w_beat already excludes
      // cpu_wen, so the two branches are mutually exclusive.
      if (cpu_wen) begin
        r_wen   <= 1'b1;
        r_waddr <= cpu_waddr;
        r_wdata <= cpu_wdata;
      end else if (w_beat) begin
        r_wen   <= 1'b1;
        r_waddr <= r_ptr;
        r_wdata <= src_data;
      end

      case (r_state)
        S_IDLE: begin
          // abort is ignored here, so a command offered alongside it still
          // starts. A zero-length command completes at once without entering
          // RUN.
          if (w_cmd_acc) begin
            r_ptr <= cmd_base;
            r_rem <= cmd_count;
            if (w_cmd_zero) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
          end else if (w_beat) begin
            // The pointer is exactly index-wide, so incrementing past the
            // top index wraps to 0. A full-depth burst touches each entry once.
            r_ptr <= r_ptr + 1'b1;
            r_rem <= r_rem - 1'b1;
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscboy_ppu_palette_loader.sv
module tb_riscboy_ppu_palette_loader;

  logic        clk;
  logic        rst_n;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [7:0]  cmd_base;
  logic [8:0]  cmd_count;
  logic        abort;
  logic        src_vld;
  logic        src_rdy;
  logic [15:0] src_data;
  logic        cpu_wen;
  logic [7:0]  cpu_waddr;
  logic [15:0] cpu_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  pram_waddr;
  logic [15:0] pram_wdata;
  logic        pram_wen;

  int n_checks = 0;
  int n_errors = 0;

  // Each pram write is logged as {addr, data}. done pulses are counted.
  logic [23:0] wlog[$];
  int          ndone = 0;

  riscboy_ppu_palette_loader #(
    .W_PIXDATA    (16),
    .W_PALETTE_IDX(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd_base  (cmd_base),
    .cmd_count (cmd_count),
    .abort     (abort),
    .src_vld   (src_vld),
    .src_rdy   (src_rdy),
    .src_data  (src_data),
    .cpu_wen   (cpu_wen),
    .cpu_waddr (cpu_waddr),
    .cpu_wdata (cpu_wdata),
    .busy      (busy),
    .done      (done),
    .pram_waddr(pram_waddr),
    .pram_wdata(pram_wdata),
    .pram_wen  (pram_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pram_wen) wlog.push_back({pram_waddr, pram_wdata});
    if (done) ndone++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 2 time units after the rising edge. Checks that
  // follow a drive wait 1 more unit, so they stay clear of the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    wlog.delete();
    ndone = 0;
  endtask

  initial begin
    int bad;
    rst_n     = 1'b0;
    cmd_vld   = 1'b0;
    cmd_base  = '0;
    cmd_count = '0;
    abort     = 1'b0;
    src_vld   = 1'b0;
    src_data  = '0;
    cpu_wen   = 1'b0;
    cpu_waddr = '0;
    cpu_wdata = '0;

    // ---- reset state
    #1;
    chk("rst_wen",   pram_wen,   0);
    chk("rst_waddr", pram_waddr, 0);
    chk("rst_wdata", pram_wdata, 0);
    chk("rst_done",  done,       0);
    chk("rst_busy",  busy,       0);
    chk("rst_cmdrdy", cmd_rdy,   1);
    chk("rst_srcrdy", src_rdy,   0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_log();

    // ---- test 1: base 0x10, count 4, continuous data
    cmd_vld = 1; cmd_base = 8'h10; cmd_count = 9'd4;
    #1 chk("t1_cmdrdy", cmd_rdy, 1);
    tick();
    cmd_vld = 0;
    src_vld = 1;
    for (int i = 0; i < 4; i++) begin
      src_data = 16'hA000 + 16'(i);
      #1;
      chk($sformatf("t1_busy%0d", i), busy, 1);
      chk($sformatf("t1_srcrdy%0d", i), src_rdy, 1);
      tick();
      chk($sformatf("t1_wen%0d", i),   pram_wen, 1);
      chk($sformatf("t1_addr%0d", i),  pram_waddr, 32'h10 + i);
      chk($sformatf("t1_data%0d", i),  pram_wdata, 32'hA000 + i);
      chk($sformatf("t1_done%0d", i),  done, (i == 3) ? 1 : 0);
    end
    src_vld = 0;
    chk("t1_busy_end", busy, 0);
    chk("t1_cmdrdy_end", cmd_rdy, 1);
    tick();
    chk("t1_done_off", done, 0);
    chk("t1_wen_off", pram_wen, 0);
    chk("t1_nwrites", wlog.size(), 4);
    chk("t1_ndone", ndone, 1);

    // ---- test 2: wrap 0xFE..0x00
    clear_log();
    cmd_vld = 1; cmd_base = 8'hFE; cmd_count = 9'd3;
    tick();
    cmd_vld = 0; src_vld = 1;
    for (int i = 0; i < 3; i++) begin
      src_data = 16'hB000 + 16'(i);
      tick();
    end
    src_vld = 0;
    tick(); tick();
    chk("t2_nwrites", wlog.size(), 3);
    chk("t2_w0", wlog[0], 24'hFE_B000);
    chk("t2_w1", wlog[1], 24'hFF_B001);
    chk("t2_w2", wlog[2], 24'h00_B002);
    chk("t2_ndone", ndone, 1);

    // ---- test 3: CPU write steals the second beat slot
    clear_log();
    cmd_vld = 1; cmd_base = 8'h40; cmd_count = 9'd4;
    tick();
    cmd_vld = 0; src_vld = 1; src_data = 16'h00C0;
    tick();
    cpu_wen = 1; cpu_waddr = 8'h80; cpu_wdata = 16'h1234; src_data = 16'h00C1;
    #1 chk("t3_srcrdy_cpu", src_rdy, 0);
    tick();
    cpu_wen = 0;
    chk("t3_cpu_wen",  pram_wen,   1);
    chk("t3_cpu_addr", pram_waddr, 32'h80);
    chk("t3_cpu_data", pram_wdata, 32'h1234);
    for (int i = 1; i < 4; i++) begin
      src_data = 16'h00C0 + 16'(i);
      tick();
    end
    src_vld = 0;
    tick(); tick();
    chk("t3_nwrites", wlog.size(), 5);
    chk("t3_w0", wlog[0], 24'h40_00C0);
    chk("t3_w1", wlog[1], 24'h80_1234);
    chk("t3_w2", wlog[2], 24'h41_00C1);
    chk("t3_w3", wlog[3], 24'h42_00C2);
    chk("t3_w4", wlog[4], 24'h43_00C3);
    chk("t3_ndone", ndone, 1);

    // ---- test 4a: zero-length command
    clear_log();
    cmd_vld = 1; cmd_base = 8'h55; cmd_count = 9'd0;
    tick();
    cmd_vld = 0;
    #1;
    chk("t4a_done", done, 1);
    chk("t4a_wen",  pram_wen, 0);
    chk("t4a_cmdrdy", cmd_rdy, 1);
    chk("t4a_busy", busy, 0);
    tick();
    chk("t4a_done_off", done, 0);
    chk("t4a_nwrites", wlog.size(), 0);
    chk("t4a_ndone", ndone, 1);

    // ---- test 4b: full-depth burst of 256 entries
    clear_log();
    cmd_vld = 1; cmd_base = 8'h00; cmd_count = 9'd256;
    tick();
    cmd_vld = 0; src_vld = 1;
    for (int i = 0; i < 256; i++) begin
      src_data = 16'h5000 + 16'(i);
      tick();
    end
    src_vld = 0;
    chk("t4b_busy_end", busy, 0);
    tick(); tick();
    chk("t4b_nwrites", wlog.size(), 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < wlog.size()) begin
        if (wlog[i] !== {8'(i), 16'h5000 + 16'(i)}) bad++;
      end else begin
        bad++;
      end
    end
    chk("t4b_entries_bad", bad, 0);
    chk("t4b_ndone", ndone, 1);

    // ---- test 5: abort after 2 of 8 beats, then immediate new command
    clear_log();
    cmd_vld = 1; cmd_base = 8'h20; cmd_count = 9'd8;
    tick();
    cmd_vld = 0; src_vld = 1;
    src_data = 16'h00D0; tick();
    src_data = 16'h00D1; tick();
    abort = 1; src_data = 16'h00D2;
    #1 chk("t5_srcrdy_abort", src_rdy, 0);
    tick();
    abort = 0; src_vld = 0;
    chk("t5_busy_after", busy, 0);
    chk("t5_cmdrdy_after", cmd_rdy, 1);
    chk("t5_done_after", done, 0);
    // abort held alongside a command in IDLE is ignored
    cmd_vld = 1; abort = 1; cmd_base = 8'h30; cmd_count = 9'd1;
    tick();
    cmd_vld = 0; abort = 0;
    chk("t5_busy_new", busy, 1);
    src_vld = 1; src_data = 16'hE000;
    tick();
    src_vld = 0;
    chk("t5_done_new", done, 1);
    chk("t5_addr_new", pram_waddr, 32'h30);
    tick();
    chk("t5_nwrites", wlog.size(), 3);
    chk("t5_w0", wlog[0], 24'h20_00D0);
    chk("t5_w1", wlog[1], 24'h21_00D1);
    chk("t5_w2", wlog[2], 24'h30_E000);
    chk("t5_ndone", ndone, 1);

    // ---- test 6: asynchronous reset mid-burst
    clear_log();
    cmd_vld = 1; cmd_base = 8'h60; cmd_count = 9'd5;
    tick();
    cmd_vld = 0; src_vld = 1;
    src_data = 16'h0F00; tick();
    src_data = 16'h0F01; tick();
    chk("t6_pre_wen", pram_wen, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_wen",   pram_wen,   0);
    chk("t6_rst_waddr", pram_waddr, 0);
    chk("t6_rst_wdata", pram_wdata, 0);
    chk("t6_rst_busy",  busy,       0);
    chk("t6_rst_done",  done,       0);
    chk("t6_rst_cmdrdy", cmd_rdy,   1);
    src_vld = 0;
    tick();
    rst_n = 1;
    tick();
    clear_log();
    cmd_vld = 1; cmd_base = 8'h70; cmd_count = 9'd1;
    tick();
    cmd_vld = 0; src_vld = 1; src_data = 16'h7777;
    tick();
    src_vld = 0;
    chk("t6_post_wen",  pram_wen,   1);
    chk("t6_post_addr", pram_waddr, 32'h70);
    chk("t6_post_data", pram_wdata, 32'h7777);
    chk("t6_post_done", done,       1);
    tick();
    chk("t6_post_nwrites", wlog.size(), 1);
    chk("t6_post_ndone", ndone, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
